// File: rtl/store_buffer_if.sv
// M-stage / DM port bundle for the posted-write store buffer.
// The master side is the M stage (and testbench); the slave side is the buffer.
interface store_buffer_if #(
  parameter int unsigned DEPTH = 4
);
  logic                      st_valid;
  logic [31:0]               st_addr;
  logic [31:0]               st_data;
  logic [1:0]                st_op;
  logic [31:0]               st_pc;
  logic                      ld_valid;
  logic [31:0]               ld_addr;
  logic [1:0]                ld_op;
  logic                      stall;
  logic                      dm_we;
  logic [31:0]               dm_addr;
  logic [31:0]               dm_wd;
  logic [1:0]                dm_op;
  logic [31:0]               dm_pc;
  logic [$clog2(DEPTH):0]    count;
  logic                      full;
  logic                      empty;

  modport master (
    output st_valid, st_addr, st_data, st_op, st_pc, ld_valid, ld_addr, ld_op,
    input  stall, dm_we, dm_addr, dm_wd, dm_op, dm_pc, count, full, empty
  );

  modport slave (
    input  st_valid, st_addr, st_data, st_op, st_pc, ld_valid, ld_addr, ld_op,
    output stall, dm_we, dm_addr, dm_wd, dm_op, dm_pc, count, full, empty
  );
endinterface

// File: rtl/store_buffer.sv
// Posted-write FIFO between M stage and DM: drains in order when the port is idle,
// stalls loads that hit a pending store word until that store has drained.
module store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic           clk,
  input  logic           reset,
  store_buffer_if.slave  bus
);
  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [31:0]      addr_q [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [1:0]       op_q   [DEPTH];
  logic [31:0]      pc_q   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PtrW-1:0]  head_q, tail_q;
  logic [PtrW:0]    count_q;

  logic full, empty, hit, enq, deq;

  assign full  = (count_q == (PtrW + 1)'(DEPTH));
  assign empty = (count_q == '0);
  assign enq   = bus.st_valid && !full;
  assign deq   = bus.dm_we;

  // Word-granular match: sub-word stores anywhere in the word still block the load.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][31:2] == bus.ld_addr[31:2])) hit = 1'b1;
    end
    hit = hit && bus.ld_valid;
  end

  always_comb begin
    bus.dm_we   = 1'b0;
    bus.dm_addr = bus.ld_addr;
    bus.dm_op   = bus.ld_op;
    bus.dm_wd   = '0;
    bus.dm_pc   = '0;
    if (!(bus.ld_valid && !hit) && !empty) begin
      bus.dm_we   = 1'b1;
      bus.dm_addr = addr_q[head_q];
      bus.dm_wd   = data_q[head_q];
      bus.dm_op   = op_q[head_q];
      bus.dm_pc   = pc_q[head_q];
    end
  end

  assign bus.stall = (bus.st_valid && full) || hit;
  assign bus.count = count_q;
  assign bus.full  = full;
  assign bus.empty = empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // head == tail with both enq and deq cannot occur: that needs empty or full.
      if (enq) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PtrW'(1);
      end
      if (deq) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PtrW'(1);
      end
      count_q <= count_q + (PtrW + 1)'(enq) - (PtrW + 1)'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
      op_q[tail_q]   <= bus.st_op;
      pc_q[tail_q]   <= bus.st_pc;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Store buffer bench: directed scenarios plus random traffic, all checked against a
// queue-based model of the posted-write buffer.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  store_buffer_if #(.DEPTH(DEPTH)) bus ();

  store_buffer #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  op;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_writes = 0;

  // Values sampled in the most recent cycle, for scenario-specific checks.
  logic        obs_stall, obs_we;
  logic [31:0] obs_addr, obs_wd, obs_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] so, input logic [31:0] sp,
                       input logic lv, input logic [31:0] la, input logic [1:0] lo);
    bus.st_valid = sv; bus.st_addr = sa; bus.st_data = sd; bus.st_op = so; bus.st_pc = sp;
    bus.ld_valid = lv; bus.ld_addr = la; bus.ld_op = lo;
  endtask

  // One clock cycle: drive at negedge, compare against the model, then advance the model.
  task automatic cycle(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                       input logic [1:0] so, input logic [31:0] sp,
                       input logic lv, input logic [31:0] la, input logic [1:0] lo);
    logic hit, exp_we, exp_stall, enq;
    ent_t e;
    @(negedge clk);
    drive(sv, sa, sd, so, sp, lv, la, lo);
    #1;
    hit = 1'b0;
    foreach (q[i]) if (lv && q[i].addr[31:2] == la[31:2]) hit = 1'b1;
    exp_we    = !(lv && !hit) && (q.size() > 0);
    exp_stall = (sv && q.size() == DEPTH) || hit;
    enq       = sv && (q.size() < DEPTH);
    check("dm_we", 32'(bus.dm_we), 32'(exp_we));
    check("stall", 32'(bus.stall), 32'(exp_stall));
    check("count", 32'(bus.count), 32'(q.size()));
    check("full",  32'(bus.full),  32'(q.size() == DEPTH));
    check("empty", 32'(bus.empty), 32'(q.size() == 0));
    if (exp_we) begin
      check("dm_addr_wr", bus.dm_addr, q[0].addr);
      check("dm_wd",      bus.dm_wd,   q[0].data);
      check("dm_op_wr",   32'(bus.dm_op), 32'(q[0].op));
      check("dm_pc",      bus.dm_pc,   q[0].pc);
    end else begin
      check("dm_addr_rd", bus.dm_addr, la);
      check("dm_op_rd",   32'(bus.dm_op), 32'(lo));
      if (!lv) begin
        check("dm_wd_idle", bus.dm_wd, 32'h0);
        check("dm_pc_idle", bus.dm_pc, 32'h0);
      end
    end
    obs_stall = bus.stall; obs_we = bus.dm_we;
    obs_addr = bus.dm_addr; obs_wd = bus.dm_wd; obs_pc = bus.dm_pc;
    @(posedge clk);
    if (exp_we) begin
      void'(q.pop_front());
      n_writes++;
    end
    if (enq) begin
      e.addr = sa; e.data = sd; e.op = so; e.pc = sp;
      q.push_back(e);
    end
  endtask

  task automatic idle();
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
    cycle(1'b1, a, d, 2'd0, p, 1'b0, 32'h0, 2'd0);
  endtask

  task automatic load(input logic [31:0] a);
    cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, a, 2'd0);
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0);
    reset = 1'b0;
    #1;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_empty", 32'(bus.empty), 32'h1);
    check("rst_full",  32'(bus.full),  32'h0);
    check("rst_we",    32'(bus.dm_we), 32'h0);
    check("rst_stall", 32'(bus.stall), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle();

    // Single store drains the next cycle.
    store(32'h10, 32'hAABBCCDD, 32'h3000);
    idle();
    check("sw_we",   32'(obs_we), 32'h1);
    check("sw_addr", obs_addr, 32'h10);
    check("sw_wd",   obs_wd,   32'hAABBCCDD);
    check("sw_pc",   obs_pc,   32'h3000);
    idle();
    check("sw_drained", 32'(bus.empty), 32'h1);

    // Back-to-back stores behind a non-hitting load stream fill the buffer.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 32'h200 + 32'(i * 4), 32'h1000 + 32'(i), 2'd0, 32'h4000 + 32'(i * 4),
            1'b1, 32'h100, 2'd0);
      if (i == 4) check("full_stall", 32'(obs_stall), 32'h1);
    end
    for (int i = 0; i < 2; i++)
      cycle(1'b1, 32'h210, 32'h1004, 2'd0, 32'h4010, 1'b0, 32'h0, 2'd0);
    repeat (5) idle();

    // Load hitting a just-stored word stalls exactly one cycle.
    store(32'h20, 32'h55, 32'h5000);
    load(32'h22);
    check("hit_stall", 32'(obs_stall), 32'h1);
    load(32'h22);
    check("hit_release_stall", 32'(obs_stall), 32'h0);
    check("hit_release_addr",  obs_addr, 32'h22);
    check("hit_release_we",    32'(obs_we), 32'h0);

    // Neighbouring word does not hit; load owns the port and count holds.
    store(32'h20, 32'h66, 32'h5004);
    load(32'h24);
    check("nohit_stall", 32'(obs_stall), 32'h0);
    check("nohit_we",    32'(obs_we), 32'h0);
    check("nohit_count", 32'(bus.count), 32'h1);
    repeat (2) idle();

    // Wrap-around: stores interleaved with short load bursts.
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 32'h300 + 32'(i * 4), 32'hC000 + 32'(i), 2'(i), 32'h6000 + 32'(i * 4),
            1'b0, 32'h0, 2'd0);
      if (i % 3 != 2) load(32'h800);
    end
    repeat (6) idle();

    // Reset mid-drain with three entries pending.
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h400 + 32'(i * 4), 32'h77 + 32'(i), 2'd0, 32'h7000, 1'b1, 32'h900, 2'd0);
    @(negedge clk);
    drive(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b0, 32'h0, 2'd0);
    check("pre_rst_count", 32'(bus.count), 32'h3);
    reset = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'h0);
    check("mid_rst_we",    32'(bus.dm_we), 32'h0);
    check("mid_rst_empty", 32'(bus.empty), 32'h1);
    q.delete();
    @(posedge clk);
    #1;
    check("held_rst_we", 32'(bus.dm_we), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) idle();

    // Random traffic over a small address pool so hits are frequent.
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      logic [31:0] a, d, p;
      logic [1:0]  op;
      r  = $urandom_range(0, 9);
      a  = 32'h40 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
      d  = $urandom;
      p  = $urandom;
      op = 2'($urandom_range(0, 2));
      if (r < 4)       cycle(1'b1, a, d, op, p, 1'b0, 32'h0, 2'd0);
      else if (r < 7)  cycle(1'b0, 32'h0, 32'h0, 2'd0, 32'h0, 1'b1, a, op);
      else if (r == 7) cycle(1'b1, a, d, op, p, 1'b1, 32'h80 + a, op);
      else             idle();
    end
    repeat (6) idle();
    check("final_empty", 32'(bus.empty), 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
